// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// eth_pkg : shared Ethernet/IPv4 RX constants and parser state encoding
// Revision: 1.0
// ============================================================================
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_DATA    = 3'd2,
    ST_PAD     = 3'd3,
    ST_DISCARD = 3'd4
  } rx_state_e;

  localparam logic [3:0] IP_VERSION_4    = 4'd4;
  localparam logic [3:0] IP_MIN_IHL      = 4'd5;
  localparam logic [7:0] PROTO_ICMP      = 8'h01;
  localparam logic [7:0] PROTO_UDP       = 8'h11;
  localparam int         ETH_MIN_PAYLOAD = 46;

endpackage
`default_nettype wire

// File: rtl/ip_hdr_checksum.sv
`default_nettype none
// ============================================================================
// ip_hdr_checksum : streaming ones'-complement sum of big-endian 16-bit words
// Revision: 1.0
// ============================================================================
module ip_hdr_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       sum_ok_o
);

  logic [31:0] acc_q;
  logic [7:0]  hi_q;
  logic        odd_q;
  logic [31:0] w_final;
  logic [31:0] w_fold1;
  logic [31:0] w_fold2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      hi_q  <= '0;
      odd_q <= 1'b0;
    end else if (clear_i) begin
      acc_q <= '0;
      hi_q  <= '0;
      odd_q <= 1'b0;
    end else if (valid_i) begin
      if (!odd_q) begin
        hi_q  <= data_i;
        odd_q <= 1'b1;
      end else begin
        acc_q <= acc_q + {16'd0, hi_q, data_i};
        odd_q <= 1'b0;
      end
    end
  end

  // Final word is folded in combinationally so the verdict is ready on the last byte.
  assign w_final  = acc_q + {16'd0, hi_q, data_i};
  assign w_fold1  = {16'd0, w_final[15:0]} + {16'd0, w_final[31:16]};
  assign w_fold2  = {16'd0, w_fold1[15:0]} + {16'd0, w_fold1[31:16]};
  assign sum_ok_o = (w_fold2[15:0] == 16'hFFFF);

endmodule
`default_nettype wire

// File: rtl/ip_rx_dispatch.sv
`default_nettype none
// ============================================================================
// ip_rx_dispatch : IPv4 RX header parser/filter and protocol payload router
// Optional: IP_RX_BROADCAST_EN accepts limited-broadcast datagrams.
// Revision: 1.0
// ============================================================================
module ip_rx_dispatch
  import eth_pkg::*;
#(
  parameter int                     NUM_PROTO  = 2,
  parameter logic [NUM_PROTO*8-1:0] PROTO_LIST = {PROTO_UDP, PROTO_ICMP}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          local_ip_addr,
  input  logic [47:0]          local_mac_addr,
  input  logic [47:0]          mac_rx_dest_mac_addr,
  input  logic                 ip_rx_req,
  input  logic                 ip_rx_valid,
  input  logic [7:0]           ip_rx_data,
  input  logic                 ip_rx_last,
  output logic [NUM_PROTO-1:0] proto_rx_req,
  output logic                 proto_rx_valid,
  output logic [7:0]           proto_rx_data,
  output logic                 proto_rx_end,
  output logic [15:0]          upper_layer_data_length,
  output logic [7:0]           net_protocol,
  output logic [31:0]          ip_rec_source_addr,
  output logic [31:0]          ip_rec_dest_addr,
  output logic                 ip_checksum_error,
  output logic                 ip_addr_check_error,
  output logic                 ip_hdr_error,
  output logic                 ip_len_error,
  output logic                 ip_proto_unsupported
);

  rx_state_e state_q, state_d;
  logic [15:0] cnt_q;
  logic [3:0]  ver_q, ver_d, ihl_q, ihl_d;
  logic [15:0] tot_q, tot_d;
  logic [7:0]  proto_q, proto_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;

  logic [NUM_PROTO-1:0] req_q, req_d;
  logic        pv_q, pv_d, end_q, end_d;
  logic [7:0]  pd_q, pd_d, np_q, np_d;
  logic [15:0] ul_q, ul_d;
  logic [31:0] srco_q, srco_d, dsto_q, dsto_d;
  logic        cks_err_q, cks_err_d, addr_err_q, addr_err_d, hdr_err_q, hdr_err_d;
  logic        len_err_q, len_err_d, unsup_q, unsup_d;

  logic        w_hdr_byte, w_hdr_last, w_hdr_bad, w_cks_ok, w_cks_clr, w_addr_ok;
  logic [3:0]  w_ihl_eff;
  logic [15:0] w_hdr_len, w_pay_len;
  logic [NUM_PROTO-1:0] w_proto_hit;

  assign w_hdr_byte = (state_q == ST_HDR) && ip_rx_valid;
  assign w_cks_clr  = (state_q == ST_IDLE);
  // An undersized IHL still consumes 20 bytes so every fixed field is seen before the verdict.
  assign w_ihl_eff  = (ihl_q < IP_MIN_IHL) ? IP_MIN_IHL : ihl_q;
  assign w_hdr_len  = {10'd0, w_ihl_eff, 2'b00};
  assign w_pay_len  = tot_q - w_hdr_len;
  assign w_hdr_last = w_hdr_byte && (cnt_q == w_hdr_len - 16'd1);
  assign w_hdr_bad  = (ver_q != IP_VERSION_4) || (ihl_q < IP_MIN_IHL) ||
                      (tot_q < {10'd0, ihl_q, 2'b00});

  ip_hdr_checksum u_cks (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (w_cks_clr),
    .valid_i  (w_hdr_byte),
    .data_i   (ip_rx_data),
    .sum_ok_o (w_cks_ok)
  );

`ifdef IP_RX_BROADCAST_EN
  logic w_mac_local, w_mac_bcast, w_ip_local, w_ip_bcast;
  assign w_mac_local = (mac_rx_dest_mac_addr == local_mac_addr);
  assign w_mac_bcast = (mac_rx_dest_mac_addr == 48'hFFFF_FFFF_FFFF);
  assign w_ip_local  = (dst_d == local_ip_addr);
  assign w_ip_bcast  = (dst_d == 32'hFFFF_FFFF);
  assign w_addr_ok   = (w_mac_local || (w_mac_bcast && w_ip_bcast)) && (w_ip_local || w_ip_bcast);
`else
  assign w_addr_ok   = (mac_rx_dest_mac_addr == local_mac_addr) && (dst_d == local_ip_addr);
`endif

  always_comb begin
    w_proto_hit = '0;
    for (int i = 0; i < NUM_PROTO; i++) begin
      if (proto_q == PROTO_LIST[8*i +: 8] && w_proto_hit == '0) w_proto_hit[i] = 1'b1;
    end
  end

  always_comb begin
    ver_d   = ver_q;
    ihl_d   = ihl_q;
    tot_d   = tot_q;
    proto_d = proto_q;
    src_d   = src_q;
    dst_d   = dst_q;
    if (w_hdr_byte) begin
      case (cnt_q)
        16'd0:                         {ver_d, ihl_d} = ip_rx_data;
        16'd2:                         tot_d[15:8]    = ip_rx_data;
        16'd3:                         tot_d[7:0]     = ip_rx_data;
        16'd9:                         proto_d        = ip_rx_data;
        16'd12, 16'd13, 16'd14, 16'd15: src_d         = {src_q[23:0], ip_rx_data};
        16'd16, 16'd17, 16'd18, 16'd19: dst_d         = {dst_q[23:0], ip_rx_data};
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = '0;
    pv_d       = 1'b0;
    pd_d       = pd_q;
    end_d      = 1'b0;
    ul_d       = ul_q;
    np_d       = np_q;
    srco_d     = srco_q;
    dsto_d     = dsto_q;
    cks_err_d  = 1'b0;
    addr_err_d = 1'b0;
    hdr_err_d  = 1'b0;
    len_err_d  = 1'b0;
    unsup_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (ip_rx_req) state_d = ST_HDR;
      ST_HDR: if (ip_rx_valid) begin
        if (w_hdr_last) begin
          ul_d   = w_pay_len;
          np_d   = proto_q;
          srco_d = src_q;
          dsto_d = dst_d;
          if (w_hdr_bad)                            begin hdr_err_d  = 1'b1; state_d = ST_DISCARD; end
          else if (!w_cks_ok)                       begin cks_err_d  = 1'b1; state_d = ST_DISCARD; end
          else if (!w_addr_ok)                      begin addr_err_d = 1'b1; state_d = ST_DISCARD; end
          else if (w_proto_hit == '0)               begin unsup_d    = 1'b1; state_d = ST_DISCARD; end
          else if (ip_rx_last && w_pay_len != 16'd0) len_err_d = 1'b1;
          else begin
            req_d   = w_proto_hit;
            state_d = (w_pay_len == 16'd0) ? ST_PAD : ST_DATA;
          end
        end else if (ip_rx_last) begin
          len_err_d = 1'b1;
        end
        if (ip_rx_last) state_d = ST_IDLE;
      end
      ST_DATA: if (ip_rx_valid) begin
        pv_d = 1'b1;
        pd_d = ip_rx_data;
        if (cnt_q == tot_q - 16'd1) begin
          end_d   = 1'b1;
          state_d = ST_PAD;
        end else if (ip_rx_last) begin
          len_err_d = 1'b1;
        end
        if (ip_rx_last) state_d = ST_IDLE;
      end
      ST_PAD, ST_DISCARD: if (ip_rx_valid && ip_rx_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ver_q   <= '0;
      ihl_q   <= '0;
      tot_q   <= '0;
      proto_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == ST_IDLE) ? 16'd0 : (ip_rx_valid ? cnt_q + 16'd1 : cnt_q);
      ver_q   <= ver_d;
      ihl_q   <= ihl_d;
      tot_q   <= tot_d;
      proto_q <= proto_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q      <= '0;
      pv_q       <= 1'b0;
      pd_q       <= '0;
      end_q      <= 1'b0;
      ul_q       <= '0;
      np_q       <= '0;
      srco_q     <= '0;
      dsto_q     <= '0;
      cks_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
      unsup_q    <= 1'b0;
    end else begin
      req_q      <= req_d;
      pv_q       <= pv_d;
      pd_q       <= pd_d;
      end_q      <= end_d;
      ul_q       <= ul_d;
      np_q       <= np_d;
      srco_q     <= srco_d;
      dsto_q     <= dsto_d;
      cks_err_q  <= cks_err_d;
      addr_err_q <= addr_err_d;
      hdr_err_q  <= hdr_err_d;
      len_err_q  <= len_err_d;
      unsup_q    <= unsup_d;
    end
  end

  assign proto_rx_req            = req_q;
  assign proto_rx_valid          = pv_q;
  assign proto_rx_data           = pd_q;
  assign proto_rx_end            = end_q;
  assign upper_layer_data_length = ul_q;
  assign net_protocol            = np_q;
  assign ip_rec_source_addr      = srco_q;
  assign ip_rec_dest_addr        = dsto_q;
  assign ip_checksum_error       = cks_err_q;
  assign ip_addr_check_error     = addr_err_q;
  assign ip_hdr_error            = hdr_err_q;
  assign ip_len_error            = len_err_q;
  assign ip_proto_unsupported    = unsup_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_rx_dispatch.sv
`default_nettype none
// ============================================================================
// tb_ip_rx_dispatch : directed frames against a datagram-level reference model
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ip_rx_dispatch;

  localparam logic [31:0] LIP   = 32'hC0A8_0001;
  localparam logic [31:0] SIP   = 32'hC0A8_0002;
  localparam logic [47:0] LMAC  = 48'h0200_0000_0001;
  localparam logic [47:0] BCMAC = 48'hFFFF_FFFF_FFFF;
  localparam int          FMIN  = eth_pkg::ETH_MIN_PAYLOAD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] mac_in = '0;
  logic        ip_rx_req = 1'b0, ip_rx_valid = 1'b0, ip_rx_last = 1'b0;
  logic [7:0]  ip_rx_data = '0;
  logic [1:0]  proto_rx_req;
  logic        proto_rx_valid, proto_rx_end;
  logic [7:0]  proto_rx_data, net_protocol;
  logic [15:0] upper_layer_data_length;
  logic [31:0] ip_rec_source_addr, ip_rec_dest_addr;
  logic        ip_checksum_error, ip_addr_check_error, ip_hdr_error, ip_len_error, ip_proto_unsupported;

  ip_rx_dispatch dut (
    .clk(clk), .rst(rst), .local_ip_addr(LIP), .local_mac_addr(LMAC),
    .mac_rx_dest_mac_addr(mac_in), .ip_rx_req(ip_rx_req), .ip_rx_valid(ip_rx_valid),
    .ip_rx_data(ip_rx_data), .ip_rx_last(ip_rx_last), .proto_rx_req(proto_rx_req),
    .proto_rx_valid(proto_rx_valid), .proto_rx_data(proto_rx_data), .proto_rx_end(proto_rx_end),
    .upper_layer_data_length(upper_layer_data_length), .net_protocol(net_protocol),
    .ip_rec_source_addr(ip_rec_source_addr), .ip_rec_dest_addr(ip_rec_dest_addr),
    .ip_checksum_error(ip_checksum_error), .ip_addr_check_error(ip_addr_check_error),
    .ip_hdr_error(ip_hdr_error), .ip_len_error(ip_len_error), .ip_proto_unsupported(ip_proto_unsupported)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int stamp; logic [7:0] d; logic e; } pay_t;
  typedef struct { int stamp; logic [6:0] v; logic [15:0] ul; logic [7:0] pr; logic [31:0] s; logic [31:0] dd; } dec_t;
  pay_t pq[$];
  dec_t dq[$];
  logic [7:0] fr[$];

  int checks = 0, failures = 0;
  int n_pay = 0, n_end = 0;
  logic [6:0] last_dv = '0;
  logic [6:0] dv;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{proto_rx_req, proto_rx_valid, proto_rx_data, proto_rx_end, upper_layer_data_length,
             net_protocol, ip_rec_source_addr, ip_rec_dest_addr, ip_checksum_error,
             ip_addr_check_error, ip_hdr_error, ip_len_error, ip_proto_unsupported};
  endfunction

  // Every-cycle comparison of DUT outputs against the expected event queues.
  always @(negedge clk) begin
    if (!rst) begin
      while (pq.size() > 0 && pq[0].stamp < cyc) begin
        checks++; failures++;
        $display("FAIL pay_missing cyc=%0d got=none exp=%h", cyc, pq[0].d);
        pq.delete(0);
      end
      while (dq.size() > 0 && dq[0].stamp < cyc) begin
        checks++; failures++;
        $display("FAIL dec_missing cyc=%0d got=none exp=%b", cyc, dq[0].v);
        dq.delete(0);
      end
      if (proto_rx_valid) begin
        n_pay++;
        if (proto_rx_end) n_end++;
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL pay_extra cyc=%0d got=%h exp=none", cyc, proto_rx_data);
        end else begin
          if (pq[0].stamp != cyc || pq[0].d !== proto_rx_data || pq[0].e !== proto_rx_end) begin
            failures++;
            $display("FAIL pay_byte cyc=%0d got=%h/end%b exp=%h/end%b@%0d", cyc, proto_rx_data,
                     proto_rx_end, pq[0].d, pq[0].e, pq[0].stamp);
          end
          pq.delete(0);
        end
      end else if (proto_rx_end) begin
        checks++; failures++;
        $display("FAIL end_without_valid cyc=%0d got=1 exp=0", cyc);
      end
      dv = {proto_rx_req, ip_checksum_error, ip_addr_check_error, ip_hdr_error, ip_len_error, ip_proto_unsupported};
      if (dv != 0) begin
        last_dv = dv;
        checks++;
        if (dq.size() == 0) begin
          failures++;
          $display("FAIL dec_extra cyc=%0d got=%b exp=none", cyc, dv);
        end else begin
          if (dq[0].stamp != cyc || dq[0].v !== dv) begin
            failures++;
            $display("FAIL dec_pulse cyc=%0d got=%b exp=%b@%0d", cyc, dv, dq[0].v, dq[0].stamp);
          end else if (dv[6:5] != 0 && (upper_layer_data_length !== dq[0].ul || net_protocol !== dq[0].pr ||
                       ip_rec_source_addr !== dq[0].s || ip_rec_dest_addr !== dq[0].dd)) begin
            failures++;
            $display("FAIL dec_fields got=%0d/%h/%h/%h exp=%0d/%h/%h/%h", upper_layer_data_length,
                     net_protocol, ip_rec_source_addr, ip_rec_dest_addr, dq[0].ul, dq[0].pr, dq[0].s, dq[0].dd);
          end
          dq.delete(0);
        end
      end
    end
  end

  task automatic make_frame(input logic [3:0] ver, input logic [3:0] ihl, input int tot,
                            input logic [7:0] pr, input logic [31:0] dst, input int flen, input bit corrupt);
    int hl;
    logic [31:0] s;
    logic [15:0] t16, ck;
    hl  = ((ihl < 5) ? 5 : int'(ihl)) * 4;
    t16 = 16'(tot);
    fr.delete();
    for (int i = 0; i < flen; i++) fr.push_back(8'(i * 7 + 3));
    fr[0] = {ver, ihl}; fr[1] = 8'h00; fr[2] = t16[15:8]; fr[3] = t16[7:0];
    fr[4] = 8'h12; fr[5] = 8'h34; fr[6] = 8'h40; fr[7] = 8'h00;
    fr[8] = 8'h40; fr[9] = pr; fr[10] = 8'h00; fr[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      fr[12 + i] = SIP[31 - 8*i -: 8];
      fr[16 + i] = dst[31 - 8*i -: 8];
    end
    for (int i = 20; i < hl; i++) fr[i] = 8'h01;
    s = 0;
    for (int w = 0; w < hl / 2; w++) s = s + {16'd0, fr[2*w], fr[2*w+1]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    ck = ~s[15:0];
    fr[10] = ck[15:8];
    fr[11] = corrupt ? (ck[7:0] ^ 8'h5A) : ck[7:0];
  endtask

  // Drives fr[] as one datagram and predicts the DUT response from the datagram rules.
  task automatic run_frame(input logic [47:0] mac, input int gap, input int abort_at);
    int flen, hl, ihl, tot;
    logic [7:0] b0, pr;
    logic [31:0] src, dst, s;
    logic [1:0] rq;
    logic [6:0] v;
    bit pass, addr_ok;
    dec_t de;
    pay_t pe;
    flen = fr.size();
    b0   = fr[0];
    ihl  = int'(b0[3:0]);
    hl   = ((ihl < 5) ? 5 : ihl) * 4;
    tot  = int'({fr[2], fr[3]});
    pr   = fr[9];
    src  = {fr[12], fr[13], fr[14], fr[15]};
    dst  = {fr[16], fr[17], fr[18], fr[19]};
    s = 0;
    for (int w = 0; w < hl / 2; w++) s = s + {16'd0, fr[2*w], fr[2*w+1]};
    while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    case (pr)
      8'h01:   rq = 2'b01;
      8'h11:   rq = 2'b10;
      default: rq = 2'b00;
    endcase
    addr_ok = (mac == LMAC) && (dst == LIP);
`ifdef IP_RX_BROADCAST_EN
    addr_ok = addr_ok || (dst == 32'hFFFF_FFFF && (mac == LMAC || mac == BCMAC));
`endif
    if (b0[7:4] != 4 || ihl < 5 || tot < ihl * 4) v = 7'b0000100;
    else if (s[15:0] != 16'hFFFF)                 v = 7'b0010000;
    else if (!addr_ok)                            v = 7'b0001000;
    else if (rq == 0)                             v = 7'b0000001;
    else if (flen == hl && tot > hl)              v = 7'b0000010;
    else                                          v = {rq, 5'b0};
    pass = (v[6:5] != 0);
    n_pay = 0; n_end = 0; last_dv = '0;
    @(posedge clk); #1;
    mac_in = mac; ip_rx_req = 1'b1;
    @(posedge clk); #1;
    ip_rx_req = 1'b0;
    for (int i = 0; i < flen; i++) begin
      if (gap > 0 && (i % gap) == gap - 1) begin
        ip_rx_valid = 1'b0; ip_rx_last = 1'b0;
        @(posedge clk); #1;
      end
      if (i == abort_at) begin
        #2 rst = 1'b1;
        ip_rx_valid = 1'b0; ip_rx_last = 1'b0;
        #1 chk("reset_abort_outputs_zero", any_out(), 0);
        pq.delete(); dq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      ip_rx_valid = 1'b1; ip_rx_data = fr[i]; ip_rx_last = (i == flen - 1);
      if (flen >= hl && i == hl - 1) begin
        de.stamp = cyc + 1; de.v = v; de.ul = 16'(tot - hl); de.pr = pr; de.s = src; de.dd = dst;
        dq.push_back(de);
      end
      if (pass && i >= hl && i < tot) begin
        pe.stamp = cyc + 1; pe.d = fr[i]; pe.e = (i == tot - 1);
        pq.push_back(pe);
      end
      if (i == flen - 1 && (flen < hl || (pass && flen > hl && flen < tot))) begin
        de.stamp = cyc + 1; de.v = 7'b0000010; de.ul = 0; de.pr = 0; de.s = 0; de.dd = 0;
        dq.push_back(de);
      end
      @(posedge clk); #1;
    end
    ip_rx_valid = 1'b0; ip_rx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pending_payload", pq.size(), 0);
    chk("pending_decision", dq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs_zero", any_out(), 0);
    rst = 1'b0;

    make_frame(4'd4, 4'd5, 28, 8'h11, LIP, 28, 1'b0); run_frame(LMAC, 0, -1);
    chk("udp_pay_count", n_pay, 8);
    chk("udp_end_count", n_end, 1);
    chk("udp_req", last_dv, 7'b1000000);
    chk("udp_ul_len", upper_layer_data_length, 8);

    make_frame(4'd4, 4'd5, 32, 8'h01, LIP, FMIN, 1'b0); run_frame(LMAC, 5, -1);
    chk("icmp_pay_count", n_pay, 12);
    chk("icmp_req", last_dv, 7'b0100000);
    chk("icmp_ul_len", upper_layer_data_length, 12);
    chk("icmp_proto", net_protocol, 8'h01);

    make_frame(4'd4, 4'd6, 34, 8'h11, LIP, FMIN, 1'b0); run_frame(LMAC, 0, -1);
    chk("opt_pay_count", n_pay, 10);
    chk("opt_ul_len", upper_layer_data_length, 10);

    make_frame(4'd4, 4'd5, 28, 8'h11, LIP, FMIN, 1'b1); run_frame(LMAC, 0, -1);
    chk("cks_pay_count", n_pay, 0);
    chk("cks_err", last_dv, 7'b0010000);

    make_frame(4'd4, 4'd5, 28, 8'h06, LIP, FMIN, 1'b0); run_frame(LMAC, 0, -1);
    chk("unsup_err", last_dv, 7'b0000001);

    make_frame(4'd4, 4'd5, 28, 8'h11, 32'hFFFF_FFFF, FMIN, 1'b0); run_frame(BCMAC, 0, -1);
`ifdef IP_RX_BROADCAST_EN
    chk("bcast_result", last_dv, 7'b1000000);
`else
    chk("bcast_result", last_dv, 7'b0001000);
`endif

    make_frame(4'd4, 4'd5, 28, 8'h11, 32'hFFFF_FFFF, FMIN, 1'b0); run_frame(48'h0200_0000_0099, 0, -1);
    chk("bcast_foreign_mac", last_dv, 7'b0001000);

    make_frame(4'd6, 4'd5, 28, 8'h11, LIP, FMIN, 1'b0); run_frame(LMAC, 0, -1);
    chk("version_err", last_dv, 7'b0000100);

    make_frame(4'd4, 4'd5, 28, 8'h11, 32'hC0A8_0005, FMIN, 1'b0); run_frame(LMAC, 0, -1);
    chk("ip_mismatch", last_dv, 7'b0001000);

    make_frame(4'd4, 4'd5, 28, 8'h11, LIP, 23, 1'b0); run_frame(LMAC, 0, -1);
    chk("early_pay_count", n_pay, 3);
    chk("early_end_count", n_end, 0);
    chk("early_len_err", last_dv, 7'b0000010);

    make_frame(4'd4, 4'd5, 20, 8'h11, LIP, FMIN, 1'b0); run_frame(LMAC, 0, -1);
    chk("zero_pay_count", n_pay, 0);
    chk("zero_ul_len", upper_layer_data_length, 0);

    make_frame(4'd4, 4'd5, 28, 8'h11, LIP, 28, 1'b0); run_frame(LMAC, 0, 24);

    make_frame(4'd4, 4'd5, 28, 8'h01, LIP, 28, 1'b0); run_frame(LMAC, 3, -1);
    chk("post_reset_pay_count", n_pay, 8);
    chk("post_reset_req", last_dv, 7'b0100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_rx_dispatch.md
# ip_rx_dispatch

Parametrised IPv4 receive parser for the Ethernet RX path, sitting between the MAC receive stage and the upper-layer receivers (UDP, ICMP, and others). It accepts a byte stream with a per-byte valid strobe and parses IHL-sized headers, including options. It verifies version, length and header checksum, filters on MAC/IP address, and routes the payload to one of `NUM_PROTO` protocol channels with exact payload framing. Ethernet padding is stripped before the payload leaves the block.

## Interface
Parameters:
- `NUM_PROTO`, default 2: number of upper-layer channels.
- `PROTO_LIST`, default `{8'h11, 8'h01}`: `NUM_PROTO`×8 bits; channel i protocol number is bits [8i+7:8i].

Ports (all outputs registered; clock and reset first):
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `local_ip_addr`  in  32  local IPv4 address.
- `local_mac_addr`  in  48  local MAC address.
- `mac_rx_dest_mac_addr`  in  48  destination MAC of the current frame; stable from `ip_rx_req` to `ip_rx_last`.
- `ip_rx_req`  in  1  start of IP datagram; first header byte is the next valid byte.
- `ip_rx_valid`  in  1  `ip_rx_data` carries a byte this cycle.
- `ip_rx_data`  in  8  datagram byte.
- `ip_rx_last`  in  1  qualifies the final byte of the Ethernet frame; valid only together with `ip_rx_valid`.
- `proto_rx_req`  out  `NUM_PROTO`  one-hot, one-cycle pulse: payload for channel i follows.
- `proto_rx_valid`  out  1  payload byte strobe.
- `proto_rx_data`  out  8  payload byte.
- `proto_rx_end`  out  1  pulses with the final `proto_rx_valid`.
- `upper_layer_data_length`  out  16  total_length − header_length.
- `net_protocol`  out  8  received protocol field.
- `ip_rec_source_addr`, `ip_rec_dest_addr`  out  32 each  received addresses.
- `ip_checksum_error`, `ip_addr_check_error`, `ip_hdr_error`, `ip_len_error`, `ip_proto_unsupported`  out  1 each  one-cycle error pulses.

## Operation
- States are IDLE, HDR, DATA, PAD and DISCARD.
- **IDLE → HDR:** on `ip_rx_req`. The request is ignored in every other state.
- **Byte counter:** 16-bit, cleared in IDLE, incremented only on `ip_rx_valid`.
- **Field capture in HDR (byte indices):**
  - 0: version and IHL.
  - 2–3: total_length.
  - 9: protocol.
  - 12–15: source address.
  - 16–19: destination address.
  - header_length = IHL×4, range 20–60.
- **Checksum:**
  - 32-bit accumulator of big-endian 16-bit words over the whole header, options included.
  - On the last header byte, the final word is added combinationally, the carries are folded twice, and the sum is valid iff the folded result is 16'hFFFF.
- **Decision at the last header byte, in priority order:**
  1. version≠4, IHL<5 or total_length<header_length → `ip_hdr_error`.
  2. Checksum bad → `ip_checksum_error`.
  3. Address mismatch (MAC≠local or IP≠local) → `ip_addr_check_error`.
  4. Protocol not in `PROTO_LIST` → `ip_proto_unsupported`.
  5. Otherwise → `proto_rx_req[i]`.
- **Decision outcome:**
  - Any error → DISCARD.
  - Pass → DATA; if the payload length is 0, go directly to PAD and emit no `proto_rx_valid`.
- **DATA:**
  - Forwards bytes 1:1, with `proto_rx_end` on byte total_length−1 of the datagram.
  - Then → PAD, or → IDLE if that byte carries `ip_rx_last`.
- **PAD and DISCARD:** swallow bytes until `ip_rx_last`, then → IDLE.
- **Early end:** `ip_rx_last` in HDR or DATA before total_length is reached → `ip_len_error` pulse, then → IDLE. In DATA, `proto_rx_end` is not asserted in that case.
- **Padding:** bytes beyond total_length (Ethernet padding up to 46) never reach `proto_rx_data`.

## Timing
- Let T be the cycle the last header byte is accepted.
- Decision pulses (`proto_rx_req` or one error flag) occur at T+1. `upper_layer_data_length`, `net_protocol` and the addresses are valid from T+1 and held until the next header.
- Payload path has a 1-cycle latency: an input byte valid at cycle N appears as `proto_rx_valid`/`proto_rx_data` at N+1. With a continuous stream, the first `proto_rx_valid` is at T+2.
- Gaps in `ip_rx_valid` propagate as gaps in `proto_rx_valid`. No backpressure.
- `ip_rx_last` in any state other than IDLE returns to IDLE at the following edge.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Asynchronous assertion mid-frame aborts immediately with no pulses.
  - After release, the block waits for the next `ip_rx_req`.

## Configuration
- `IP_RX_BROADCAST_EN` defined:
  - Destination IP 255.255.255.255 with destination MAC FF:FF:FF:FF:FF:FF also passes the address check.
  - Broadcast IP alone, with a unicast MAC, still passes only if the MAC equals local.
- `IP_RX_BROADCAST_EN` undefined: only an exact local MAC and local IP pass.

## Structure
- Shared package `eth_pkg` holds:
  - state encodings;
  - `IP_VERSION_4`, `IP_MIN_IHL`;
  - default protocol numbers `PROTO_ICMP` = 8'h01 and `PROTO_UDP` = 8'h11;
  - `ETH_MIN_PAYLOAD` = 46.
- One sub-module: `ip_hdr_checksum`. It is a streaming 16-bit ones'-complement accumulator with clear, byte-valid and a final-word combinational check output. The same sub-module is reused by the TX side.

## Test plan
- 20-byte header with a valid checksum, UDP, local addresses, total_length 28, no padding → `proto_rx_req`=2'b10 at T+1, 8 payload bytes, `proto_rx_end` on the 8th, `upper_layer_data_length`=8.
- ICMP, total_length 32 in a 46-byte frame → 12 payload bytes forwarded, 14 padding bytes suppressed, returns to IDLE on `ip_rx_last`.
- IHL=6 with a 4-byte option, valid checksum → payload starts after byte 23, `upper_layer_data_length`=total_length−24.
- Header checksum byte flipped → `ip_checksum_error` pulse at T+1, zero `proto_rx_valid`.
- Protocol 8'h06 → `ip_proto_unsupported`. Destination IP 255.255.255.255 with broadcast MAC → passes only when `IP_RX_BROADCAST_EN` is defined, `ip_addr_check_error` otherwise.
- `ip_rx_last` at payload byte 3 of 8 → `ip_len_error`, no `proto_rx_end`. Async `rst` asserted mid-DATA → all outputs 0; the next frame parses correctly.
